// File: rtl/seq_divider.sv
// Sequential restoring divider: one quotient bit per clock, start/busy/done handshake.
// Define SIGNED_DIV_EN for two's-complement operands; the default build is unsigned only.
module seq_divider #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             busy,
  output logic             done,
  output logic             div_zero
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] ZCHK = 2'd1;
  localparam logic [1:0] RUN  = 2'd2;
  localparam logic [1:0] FIN  = 2'd3;

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  logic [1:0]       state;
  logic [WIDTH-1:0] q_work;  // dividend bits shift out as quotient bits shift in
  logic [WIDTH-1:0] r_work;  // always < divisor between steps, so WIDTH bits suffice
  logic [WIDTH-1:0] dvs;
  logic [CW-1:0]    cnt;
  logic             dz;

  logic [WIDTH:0]   r_shift;
  logic             ge;
  logic [WIDTH-1:0] dvd_mag;
  logic [WIDTH-1:0] dvs_mag;
  logic [WIDTH-1:0] zchk_raw;
  logic [WIDTH-1:0] q_fin;
  logic [WIDTH-1:0] r_fin;

`ifdef SIGNED_DIV_EN
  logic [WIDTH-1:0] raw_dvd;
  logic             neg_q;
  logic             neg_r;
`endif

  // NOTE: every variable assigned in always_comb gets a default first so no latch is inferred.
  always_comb begin
    r_shift  = {r_work, q_work[WIDTH-1]};
    ge       = (r_shift >= {1'b0, dvs});
    dvd_mag  = dividend;
    dvs_mag  = divisor;
    zchk_raw = q_work;
    q_fin    = q_work;
    r_fin    = r_work;
`ifdef SIGNED_DIV_EN
    // Magnitude of the most-negative value is 2^(WIDTH-1), which still fits unsigned.
    if (dividend[WIDTH-1]) dvd_mag = -dividend;
    if (divisor[WIDTH-1])  dvs_mag = -divisor;
    zchk_raw = raw_dvd;
    if (!dz) begin
      if (neg_q) q_fin = -q_work;
      if (neg_r) r_fin = -r_work;
    end
`endif
  end

  // NOTE: sequential state uses non-blocking assignments only; the working registers are
  // reset along with the outputs so no X can leak into a result after reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      quotient  <= '0;
      remainder <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      div_zero  <= 1'b0;
      q_work    <= '0;
      r_work    <= '0;
      dvs       <= '0;
      cnt       <= '0;
      dz        <= 1'b0;
`ifdef SIGNED_DIV_EN
      raw_dvd   <= '0;
      neg_q     <= 1'b0;
      neg_r     <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            q_work <= dvd_mag;
            dvs    <= dvs_mag;
            r_work <= '0;
            cnt    <= '0;
            dz     <= 1'b0;
            busy   <= 1'b1;
            state  <= ZCHK;
`ifdef SIGNED_DIV_EN
            raw_dvd <= dividend;
            neg_q   <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
            neg_r   <= dividend[WIDTH-1];
`endif
          end
        end
        ZCHK: begin
          if (dvs == '0) begin
            q_work <= '1;
            r_work <= zchk_raw;
            dz     <= 1'b1;
            state  <= FIN;
          end else begin
            state <= RUN;
          end
        end
        RUN: begin
          r_work <= ge ? WIDTH'(r_shift - {1'b0, dvs}) : r_shift[WIDTH-1:0];
          q_work <= {q_work[WIDTH-2:0], ge};
          cnt    <= cnt + CW'(1);
          if (cnt == LAST) state <= FIN;
        end
        FIN: begin
          quotient  <= q_fin;
          remainder <= r_fin;
          div_zero  <= dz;
          done      <= 1'b1;
          busy      <= 1'b0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_divider.sv
// Scoreboard bench for seq_divider: the driver queues expected results from an arithmetic
// model, a negedge monitor pops and compares on every done pulse.
module tb_seq_divider;
  localparam int W   = 8;
  localparam int LAT = W + 2;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] dividend = '0;
  logic [W-1:0] divisor = '0;
  logic [W-1:0] quotient, remainder;
  logic         busy, done, div_zero;

  seq_divider #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .dividend(dividend), .divisor(divisor),
    .quotient(quotient), .remainder(remainder), .busy(busy), .done(done), .div_zero(div_zero)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         dz;
    int           done_cyc;
  } exp_t;

  exp_t exp_q[$];
  int   cyc = 0;
  int   n_vec = 0;
  int   n_err = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t e;
    e.done_cyc = 0;
    if (b == '0) begin
      e.q  = '1;
      e.r  = a;
      e.dz = 1'b1;
    end else begin
      e.dz = 1'b0;
`ifdef SIGNED_DIV_EN
      begin
        int sa, sb;
        sa = $signed(a);
        sb = $signed(b);
        e.q = W'(sa / sb);
        e.r = W'(sa % sb);
      end
`else
      e.q = a / b;
      e.r = a % b;
`endif
    end
    return e;
  endfunction

  // Monitor: scores every done pulse and checks outputs hold steady while busy.
  exp_t         mon_e;
  logic [W-1:0] held_q = '0, held_r = '0;
  logic         held_dz = 1'b0;

  always @(negedge clk) begin
    if (rst_n && done) begin
      if (exp_q.size() == 0) begin
        check("spurious_done", done, 0);
      end else begin
        mon_e = exp_q.pop_front();
        check("quotient", quotient, mon_e.q);
        check("remainder", remainder, mon_e.r);
        check("div_zero", div_zero, mon_e.dz);
        check("done_cycle", cyc, mon_e.done_cyc);
        check("busy_at_done", busy, 0);
      end
    end
    if (busy) begin
      check("hold_quotient", quotient, held_q);
      check("hold_remainder", remainder, held_r);
      check("hold_div_zero", div_zero, held_dz);
    end else begin
      held_q  = quotient;
      held_r  = remainder;
      held_dz = div_zero;
    end
  end

  // Called at posedge+1 when the DUT will be idle at the next edge.
  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t e;
    start    = 1'b1;
    dividend = a;
    divisor  = b;
    @(posedge clk); #1;
    start = 1'b0;
    e = model(a, b);
    e.done_cyc = cyc + ((b == '0) ? 2 : LAT);
    exp_q.push_back(e);
    check("busy_after_start", busy, 1);
  endtask

  task automatic wait_idle();
    int n = 0;
    while (exp_q.size() != 0 && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    if (exp_q.size() != 0) begin
      check("done_timeout", exp_q.size(), 0);
      exp_q.delete();
    end
  endtask

  // Issues the next operation in the very cycle done is high.
  task automatic issue_on_done(input logic [W-1:0] a, input logic [W-1:0] b);
    int n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (!done && n < 40);
    if (!done) begin
      check("done_timeout", done, 1);
      exp_q.delete();
    end
    issue(a, b);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [W-1:0] a, b;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_quotient", quotient, 0);
    check("reset_remainder", remainder, 0);
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_div_zero", div_zero, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    issue(8'd100, 8'd7);
    wait_idle();
    issue(8'hC8, 8'd0);
    issue_on_done(8'd9, 8'd3);
    wait_idle();

    // start toggled with other operands while busy must be ignored
    issue(8'd100, 8'd7);
    repeat (6) begin
      start    = 1'($urandom);
      dividend = W'($urandom);
      divisor  = W'($urandom);
      @(posedge clk); #1;
    end
    start = 1'b0;
    issue_on_done(8'd50, 8'd5);
    wait_idle();

    issue(8'd255, 8'd1);   wait_idle();
    issue(8'd5, 8'd9);     wait_idle();
    issue(8'd255, 8'd255); wait_idle();
    issue(8'd0, 8'd1);     wait_idle();
`ifdef SIGNED_DIV_EN
    issue(8'h9C, 8'd7);    wait_idle();
    issue(8'd100, 8'hF9);  wait_idle();
    issue(8'h80, 8'hFF);   wait_idle();
    issue(8'h80, 8'd1);    wait_idle();
    issue(8'h9C, 8'd0);    wait_idle();
`endif

    // reset at cycle 5 of an operation discards it
    issue(8'd200, 8'd7);
    repeat (4) @(posedge clk);
    #1;
    rst_n = 1'b0;
    exp_q.delete();
    @(posedge clk); #1;
    check("midreset_quotient", quotient, 0);
    check("midreset_remainder", remainder, 0);
    check("midreset_busy", busy, 0);
    check("midreset_done", done, 0);
    check("midreset_div_zero", div_zero, 0);
    rst_n = 1'b1;
    repeat (14) @(posedge clk);
    #1;
    issue(8'd255, 8'd16);
    wait_idle();

    for (int i = 0; i < 40; i++) begin
      a = W'($urandom);
      b = ($urandom_range(0, 7) == 0) ? '0 : W'($urandom);
      if ($urandom_range(0, 2) == 0 && exp_q.size() != 0) begin
        issue_on_done(a, b);
      end else begin
        wait_idle();
        issue(a, b);
      end
    end
    wait_idle();
    repeat (3) @(posedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
